// File: rtl/wb_arbiter_pkg.sv
// Shared constants and the load-result FIFO entry layout for the writeback arbiter.
package wb_arbiter_pkg;

    localparam int REG_AW     = 5;
    localparam int DW_DEFAULT = 32;

    typedef struct packed {
        logic [REG_AW-1:0]     rd;
        logic [DW_DEFAULT-1:0] data;
        logic                  cancelled;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO: circular storage with per-entry cancel marking against a
// destination register broadcast by the arbiter.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic [REG_AW-1:0]       push_rd_i,
    input  logic [DW-1:0]           push_data_i,
    input  logic                    pop_i,
    input  logic                    cancel_i,
    input  logic [REG_AW-1:0]       cancel_rd_i,
    output logic [REG_AW-1:0]       head_rd_o,
    output logic [DW-1:0]           head_data_o,
    output logic                    head_cancelled_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DW-1:0]     data;
        logic              cancelled;
    } entry_t;

    entry_t         mem_q [DEPTH];
    entry_t         mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push_s;
    logic           do_pop_s;

    assign do_push_s = push_i && (count_q != CW'(DEPTH));
    assign do_pop_s  = pop_i && (count_q != {CW{1'b0}});

    // Next-state storage: write the pushed slot, otherwise accumulate cancel hits
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (do_push_s && (wr_ptr_q == PW'(i))) begin
                // A load arriving alongside a matching ALU write is already stale
                mem_d[i].rd        = push_rd_i;
                mem_d[i].data      = push_data_i;
                mem_d[i].cancelled = cancel_i && (push_rd_i == cancel_rd_i);
            end else begin
                mem_d[i].cancelled = mem_q[i].cancelled
                                   | (cancel_i && (mem_q[i].rd == cancel_rd_i));
            end
        end
    end

    // Next-state pointers and occupancy; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = do_push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = do_pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_rd_o        = mem_q[rd_ptr_q].rd;
    assign head_data_o      = mem_q[rd_ptr_q].data;
    assign head_cancelled_o = mem_q[rd_ptr_q].cancelled;
    assign count_o          = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take the register-file port, queued loads fill idle
// cycles. Define WB_STALL_CNT_EN to add the stall_cnt port and counter.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    input  logic [REG_AW-1:0]       alu_rd,
    input  logic [DW-1:0]           alu_data,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [REG_AW-1:0]       ld_rd,
    input  logic [DW-1:0]           ld_data,
    output logic                    RegWrite,
    output logic [REG_AW-1:0]       A3,
    output logic [DW-1:0]           WD3,
`ifdef WB_STALL_CNT_EN
    output logic [15:0]             stall_cnt,
`endif
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]     count_s;
    logic              pop_s;
    logic [REG_AW-1:0] head_rd_s;
    logic [DW-1:0]     head_data_s;
    logic              head_cancelled_s;

    logic              we_q, we_d;
    logic [REG_AW-1:0] a3_q, a3_d;
    logic [DW-1:0]     wd_q, wd_d;

    assign ld_ready = (count_s != CW'(DEPTH));
    assign pop_s    = !alu_valid && (count_s != {CW{1'b0}});

    wb_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk              (clk),
        .rst              (rst),
        .push_i           (ld_valid),
        .push_rd_i        (ld_rd),
        .push_data_i      (ld_data),
        .pop_i            (pop_s),
        .cancel_i         (alu_valid),
        .cancel_rd_i      (alu_rd),
        .head_rd_o        (head_rd_s),
        .head_data_o      (head_data_s),
        .head_cancelled_o (head_cancelled_s),
        .count_o          (count_s)
    );

    // Port selection: ALU first, then FIFO head; x0 and cancelled writes are suppressed
    always_comb begin
        we_d = 1'b0;
        a3_d = a3_q;
        wd_d = wd_q;
        if (alu_valid) begin
            we_d = (alu_rd != {REG_AW{1'b0}});
            a3_d = alu_rd;
            wd_d = alu_data;
        end else if (pop_s) begin
            we_d = (head_rd_s != {REG_AW{1'b0}}) && !head_cancelled_s;
            a3_d = head_rd_s;
            wd_d = head_data_s;
        end else begin
            we_d = 1'b0;
            a3_d = a3_q;
            wd_d = wd_q;
        end
    end

    // Registered register-file write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q <= 1'b0;
            a3_q <= {REG_AW{1'b0}};
            wd_q <= {DW{1'b0}};
        end else begin
            we_q <= we_d;
            a3_q <= a3_d;
            wd_q <= wd_d;
        end
    end

    assign RegWrite   = we_q;
    assign A3         = a3_q;
    assign WD3        = wd_q;
    assign fifo_count = count_s;

`ifdef WB_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of cycles a queued load is held off by the ALU
    always_comb begin
        if (alu_valid && (count_s != {CW{1'b0}}) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (DW=32, DEPTH=4).
module tb_wb_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [DW-1:0] alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [4:0]    ld_rd;
    logic [DW-1:0] ld_data;
    logic          RegWrite;
    logic [4:0]    A3;
    logic [DW-1:0] WD3;
    logic [2:0]    fifo_count;
`ifdef WB_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .RegWrite   (RegWrite),
        .A3         (A3),
        .WD3        (WD3),
`ifdef WB_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .fifo_count (fifo_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_data = '0;
        #1;
        check_eq("rst_regwrite", RegWrite, 0);
        check_eq("rst_a3", A3, 0);
        check_eq("rst_wd3", WD3, 0);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_ld_ready", ld_ready, 1);
`ifdef WB_STALL_CNT_EN
        check_eq("rst_stall", stall_cnt, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single ALU write, visible one cycle later, then idle hold
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
        tick();
        check_eq("alu_we", RegWrite, 1);
        check_eq("alu_a3", A3, 5);
        check_eq("alu_wd3", WD3, 32'h11);
        alu_valid = 1'b0;
        tick();
        check_eq("idle_we", RegWrite, 0);
        check_eq("idle_a3_hold", A3, 5);
        check_eq("idle_wd3_hold", WD3, 32'h11);

        // fill the FIFO while the ALU owns the port
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99; ld_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ld_rd = 5'(i); ld_data = 32'h100 + i;
            tick();
        end
        check_eq("fill_count", fifo_count, 4);
        check_eq("fill_ready", ld_ready, 0);
        check_eq("fill_alu_a3", A3, 9);
        ld_rd = 5'd5; ld_data = 32'h105;
        tick();
        check_eq("full_refuse_count", fifo_count, 4);
        alu_valid = 1'b0; ld_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("drain_we", RegWrite, 1);
            check_eq("drain_a3", A3, i);
            check_eq("drain_wd3", WD3, 32'h100 + i);
            check_eq("drain_count", fifo_count, 4 - i);
        end
        tick();
        check_eq("drained_we", RegWrite, 0);

        // simultaneous push and pop keeps the count
        ld_valid = 1'b1; ld_rd = 5'd8; ld_data = 32'h88;
        tick();
        check_eq("pp_first_count", fifo_count, 1);
        check_eq("pp_first_we", RegWrite, 0);
        ld_rd = 5'd10; ld_data = 32'hA0;
        tick();
        check_eq("pp_we", RegWrite, 1);
        check_eq("pp_a3", A3, 8);
        check_eq("pp_count", fifo_count, 1);
        ld_valid = 1'b0;
        tick();
        check_eq("pp_second_a3", A3, 10);
        check_eq("pp_second_wd3", WD3, 32'hA0);
        check_eq("pp_second_count", fifo_count, 0);

        // younger ALU write cancels a queued load
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hAA;
        tick();
        ld_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hBB;
        tick();
        check_eq("cancel_alu_we", RegWrite, 1);
        check_eq("cancel_alu_a3", A3, 7);
        check_eq("cancel_alu_wd3", WD3, 32'hBB);
        check_eq("cancel_held_count", fifo_count, 1);
        alu_valid = 1'b0;
        tick();
        check_eq("cancel_pop_we", RegWrite, 0);
        check_eq("cancel_pop_count", fifo_count, 0);

        // load pushed in the same cycle as a matching ALU write
        ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'hCC;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'hDD;
        tick();
        check_eq("samecyc_we", RegWrite, 1);
        check_eq("samecyc_wd3", WD3, 32'hDD);
        check_eq("samecyc_count", fifo_count, 1);
        ld_valid = 1'b0; alu_valid = 1'b0;
        tick();
        check_eq("samecyc_pop_we", RegWrite, 0);
        check_eq("samecyc_pop_count", fifo_count, 0);

        // writes to x0 are dropped
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        tick();
        check_eq("x0_alu_we", RegWrite, 0);
        alu_valid = 1'b0; ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h66;
        tick();
        check_eq("x0_ld_count", fifo_count, 1);
        ld_valid = 1'b0;
        tick();
        check_eq("x0_ld_pop_count", fifo_count, 0);
        check_eq("x0_ld_we", RegWrite, 0);

        // reset mid-run discards queued loads
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99; ld_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            ld_rd = 5'(i); ld_data = 32'h200 + i;
            tick();
        end
        check_eq("pre_rst_count", fifo_count, 3);
        alu_valid = 1'b0; ld_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("midrst_count", fifo_count, 0);
        check_eq("midrst_ready", ld_ready, 1);
        check_eq("midrst_we", RegWrite, 0);
        check_eq("midrst_a3", A3, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("post_rst_we", RegWrite, 0);
            check_eq("post_rst_count", fifo_count, 0);
        end

`ifdef WB_STALL_CNT_EN
        // one entry held off for ten ALU cycles
        check_eq("stall_after_rst", stall_cnt, 0);
        ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'hC0;
        tick();
        ld_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        repeat (10) tick();
        check_eq("stall_cnt10", stall_cnt, 10);
        check_eq("stall_count", fifo_count, 1);
        alu_valid = 1'b0;
        tick();
        check_eq("stall_hold", stall_cnt, 10);
        check_eq("stall_pop_a3", A3, 12);
        check_eq("stall_pop_we", RegWrite, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DW, default 32: register data width.
REQ-002 Parameter DEPTH, default 4: load-result FIFO depth; the block SHALL support only powers of two, minimum 2.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 alu_valid  in  1  ALU result present this cycle; no backpressure.
REQ-006 alu_rd  in  5  ALU destination register.
REQ-007 alu_data  in  DW  ALU result.
REQ-008 ld_valid  in  1  load result offered.
REQ-009 ld_ready  out  1  FIFO can accept a load result.
REQ-010 ld_rd  in  5  load destination register.
REQ-011 ld_data  in  DW  load data.
REQ-012 RegWrite  out  1  register file write enable.
REQ-013 A3  out  5  register file write address.
REQ-014 WD3  out  DW  register file write data.
REQ-015 fifo_count  out  $clog2(DEPTH)+1  number of FIFO entries.

Function
REQ-016 The block SHALL merge the two result sources onto the single register file write port, with RegWrite/A3/WD3 registered, so a selected write appears exactly one cycle after selection.
REQ-017 A load result SHALL be accepted when ld_valid && ld_ready, and ld_ready SHALL equal (fifo_count != DEPTH), combinational from count only.
REQ-018 Each cycle, alu_valid SHALL win the port; otherwise, if the FIFO is non-empty, the head SHALL be popped and driven.
REQ-019 A simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-020 Any selected write with rd == 0 SHALL be dropped (RegWrite=0); a FIFO pop still consumes the entry.
REQ-021 When alu_valid, every FIFO entry with rd == alu_rd, including one pushed in the same cycle, SHALL be marked cancelled (younger ALU write wins).
REQ-022 A cancelled entry SHALL still be popped in order, with RegWrite=0 for that cycle.
REQ-023 The FIFO SHALL hold when alu_valid every cycle (starvation permitted); loads then stall via ld_ready.
REQ-024 In idle cycles RegWrite SHALL be 0; A3/WD3 SHALL hold their last value.

Reset
REQ-025 On rst, RegWrite=0, A3=0, WD3=0, fifo_count=0, pointers=0, all cancel bits cleared, and ld_ready=1 immediately (combinational).
REQ-026 rst asserted mid-operation SHALL discard all queued entries without issuing a write.

Configuration
REQ-027 With WB_STALL_CNT_EN defined, the block SHALL add output stall_cnt (16 bits), a counter that increments each cycle the FIFO is non-empty and alu_valid blocks the pop, saturates at 16'hFFFF, and is cleared by rst.
REQ-028 Without WB_STALL_CNT_EN, the port and the counter SHALL be absent.

Structure
REQ-029 A shared package SHALL hold the register-address width constant (5), the DW default, and the FIFO entry struct {rd, data, cancelled}.
REQ-030 The FIFO SHALL be a sub-module wb_fifo (storage, pointers, count, per-entry cancel-match input); the arbitration SHALL be done in wb_arbiter.

Verification
REQ-031 Single ALU write: alu_valid=1, rd=5, data=0x11 in cycle N -> RegWrite=1, A3=5, WD3=0x11 in cycle N+1; RegWrite=0 in N+2.
REQ-032 Fill: 4 loads rd=1..4 pushed while alu_valid=1 -> fifo_count=4, ld_ready=0; after alu_valid drops -> 4 writes rd=1,2,3,4 in order on consecutive cycles.
REQ-033 Cancel: load rd=7, data=0xAA queued, then ALU rd=7, data=0xBB -> ALU writes 0xBB; the later pop of the load has RegWrite=0.
REQ-034 x0: ALU rd=0 -> RegWrite stays 0; load rd=0 -> popped, fifo_count decrements, and RegWrite stays 0.
REQ-035 Reset mid-run: 3 entries queued, rst pulsed -> fifo_count=0, ld_ready=1, and no write issued afterwards.
REQ-036 With WB_STALL_CNT_EN: 1 entry queued and alu_valid=1 for 10 cycles -> stall_cnt=10.
